pet_button_conditioner: RTL and testbench

- Input stage directly upstream of the pet state up/down controller.
- Converts four raw, bouncy, asynchronous push-buttons into clean single-cycle pulses.
- Drives that controller's food_button, heal_button, state_button and test_signal inputs.
- test_signal fires only on a long press, so test mode cannot be toggled by an accidental tap.

---
 rtl/pet_button_conditioner.sv | 233 +++++++++++++++++++++++
 tb/tb_pet_button_conditioner.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pet_button_conditioner.sv
// Four-button synchronizer/debouncer that feeds the pet state controller with clean one-cycle pulses.
// Optional build macro STATE_AUTOREPEAT_EN adds auto-repeat pulses on state_button while it is held.

module pet_button_chan #(
    parameter int DEB_CYCLES    = 4,
    parameter int LONG_CYCLES   = 20,
    parameter int REPEAT_CYCLES = 8,
    parameter bit LONG_PRESS    = 1'b0,
    parameter bit AUTO_REPEAT   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_pulse,
    output logic o_held
);
    localparam int DEB_W  = $clog2(DEB_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_HELD        = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [DEB_W-1:0] r_cnt;
    logic [DEB_W-1:0] w_cnt_nxt;
    logic             w_press;
    logic             w_stay_held;
    logic             w_long_fire;
    logic             w_rep_hit;
    logic             w_fire;
    logic             r_pulse;
    logic             r_held;

    // Two-flop synchronizer: the raw pin is never used past this point
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM state and stability counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= {DEB_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; the counter is cleared on every state change
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = {DEB_W{1'b0}};
        w_press     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_sync2) begin
                    w_state_nxt = ST_PRESS_CHK;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PRESS_CHK: begin
                if (!r_sync2) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt = ST_HELD;
                    w_press     = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + DEB_W'(1);
                end
            end
            ST_HELD: begin
                if (!r_sync2) begin
                    w_state_nxt = ST_RELEASE_CHK;
                end else begin
                    w_state_nxt = ST_HELD;
                end
            end
            ST_RELEASE_CHK: begin
                if (r_sync2) begin
                    w_state_nxt = ST_HELD;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + DEB_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_stay_held = (r_state == ST_HELD) && (w_state_nxt == ST_HELD);

    generate
        if (LONG_PRESS) begin : g_long
            localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
            logic [HOLD_W-1:0] r_hold;

            // Hold-time counter; saturation guarantees a single long-press pulse per press
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_hold <= {HOLD_W{1'b0}};
                end else if (!r_held) begin
                    r_hold <= {HOLD_W{1'b0}};
                end else if (r_hold != HOLD_MAX) begin
                    r_hold <= r_hold + HOLD_W'(1);
                end else begin
                    r_hold <= r_hold;
                end
            end

            assign w_long_fire = r_held && (r_hold == HOLD_FIRE);
        end else begin : g_no_long
            assign w_long_fire = 1'b0;
        end

        if (AUTO_REPEAT) begin : g_repeat
            localparam logic [HOLD_W-1:0] REP_RELOAD = HOLD_W'(LONG_CYCLES - REPEAT_CYCLES);
            logic [HOLD_W-1:0] r_rep;

            // Repeat timer: restarts whenever HELD is (re)entered, then reloads to give the repeat period
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_rep <= {HOLD_W{1'b0}};
                end else if (r_state != ST_HELD) begin
                    r_rep <= {HOLD_W{1'b0}};
                end else if (r_rep == HOLD_FIRE) begin
                    r_rep <= REP_RELOAD;
                end else begin
                    r_rep <= r_rep + HOLD_W'(1);
                end
            end

            assign w_rep_hit = (r_rep == HOLD_FIRE);
        end else begin : g_no_repeat
            assign w_rep_hit = 1'b0;
        end
    endgenerate

    assign w_fire = LONG_PRESS ? w_long_fire : (w_press | (w_rep_hit & w_stay_held));

    // Registered pulse and debounced level outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pulse <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_pulse <= w_fire;
            r_held  <= (w_state_nxt == ST_HELD) || (w_state_nxt == ST_RELEASE_CHK);
        end
    end

    assign o_pulse = r_pulse;
    assign o_held  = r_held;
endmodule

module pet_button_conditioner #(
    parameter int DEB_CYCLES    = 4,
    parameter int LONG_CYCLES   = 20,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       food_raw,
    input  logic       heal_raw,
    input  logic       state_raw,
    input  logic       test_raw,
    output logic       food_button,
    output logic       heal_button,
    output logic       state_button,
    output logic       test_signal,
    output logic [3:0] btn_held
);
`ifdef STATE_AUTOREPEAT_EN
    localparam bit STATE_REPEAT = 1'b1;
`else
    localparam bit STATE_REPEAT = 1'b0;
`endif

    logic w_held_food;
    logic w_held_heal;
    logic w_held_state;
    logic w_held_test;

    pet_button_chan #(
        .DEB_CYCLES(DEB_CYCLES), .LONG_CYCLES(LONG_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES),
        .LONG_PRESS(1'b0), .AUTO_REPEAT(1'b0)
    ) u_food (
        .i_clk(clk), .i_rst_n(rst), .i_raw(food_raw), .o_pulse(food_button), .o_held(w_held_food)
    );

    pet_button_chan #(
        .DEB_CYCLES(DEB_CYCLES), .LONG_CYCLES(LONG_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES),
        .LONG_PRESS(1'b0), .AUTO_REPEAT(1'b0)
    ) u_heal (
        .i_clk(clk), .i_rst_n(rst), .i_raw(heal_raw), .o_pulse(heal_button), .o_held(w_held_heal)
    );

    pet_button_chan #(
        .DEB_CYCLES(DEB_CYCLES), .LONG_CYCLES(LONG_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES),
        .LONG_PRESS(1'b0), .AUTO_REPEAT(STATE_REPEAT)
    ) u_state (
        .i_clk(clk), .i_rst_n(rst), .i_raw(state_raw), .o_pulse(state_button), .o_held(w_held_state)
    );

    // Test mode only toggles on a long press, never on the initial accept
    pet_button_chan #(
        .DEB_CYCLES(DEB_CYCLES), .LONG_CYCLES(LONG_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES),
        .LONG_PRESS(1'b1), .AUTO_REPEAT(1'b0)
    ) u_test (
        .i_clk(clk), .i_rst_n(rst), .i_raw(test_raw), .o_pulse(test_signal), .o_held(w_held_test)
    );

    assign btn_held = {w_held_test, w_held_state, w_held_heal, w_held_food};
endmodule

// File: tb/tb_pet_button_conditioner.sv
// Randomized self-checking bench for pet_button_conditioner against a sliding-window debounce model.
module tb_pet_button_conditioner;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;
    localparam int unsigned MASK = (32'd1 << (DEB + 1)) - 32'd1;

    logic       clk = 1'b0;
    logic       rst;
    logic       food_raw, heal_raw, state_raw, test_raw;
    logic       food_button, heal_button, state_button, test_signal;
    logic [3:0] btn_held;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: a level is accepted once DEB+1 consecutive synchronized samples agree
    int unsigned sh [4];
    bit          lvl [4];
    int          len [4];
    int          hrun;
    logic [3:0]  exp_pulse;
    logic [3:0]  exp_held;

    always #5 clk = ~clk;

    pet_button_conditioner #(.DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)) dut (
        .clk(clk), .rst(rst),
        .food_raw(food_raw), .heal_raw(heal_raw), .state_raw(state_raw), .test_raw(test_raw),
        .food_button(food_button), .heal_button(heal_button), .state_button(state_button),
        .test_signal(test_signal), .btn_held(btn_held)
    );

    function automatic logic [7:0] dut_vec();
        return {test_signal, state_button, heal_button, food_button, btn_held};
    endfunction

    task automatic model_clear();
        for (int b = 0; b < 4; b++) begin
            sh[b] = 0; lvl[b] = 1'b0; len[b] = 0;
        end
        hrun = 0; exp_pulse = 4'b0000; exp_held = 4'b0000;
    endtask

    task automatic model_update(input logic [3:0] raw);
        int unsigned win;
        bit prev, s_now, held_now;
        int plen;
        if (rst !== 1'b1) begin
            model_clear();
        end else begin
            for (int b = 0; b < 4; b++) begin
                sh[b] = ((sh[b] << 1) | 32'(raw[b])) & 32'hFFFF;
                win   = (sh[b] >> 2) & MASK;
                prev  = lvl[b];
                plen  = len[b];
                if (win == MASK) lvl[b] = 1'b1;
                else if (win == 0) lvl[b] = 1'b0;
                len[b] = lvl[b] ? len[b] + 1 : 0;
                exp_pulse[b] = (b == 3) ? (plen == LONG) : (lvl[b] && !prev);
                exp_held[b]  = lvl[b];
            end
            s_now    = sh[2][2];
            held_now = lvl[2] && s_now;
`ifdef STATE_AUTOREPEAT_EN
            if (held_now && hrun >= LONG && ((hrun - LONG) % REP) == 0) exp_pulse[2] = 1'b1;
`endif
            hrun = held_now ? hrun + 1 : 0;
        end
    endtask

    task automatic tick(input logic [3:0] raw);
        {test_raw, state_raw, heal_raw, food_raw} = raw;
        @(posedge clk);
        model_update(raw);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) begin
            tick(4'($urandom));
            n_checks++;
            if (dut_vec() !== 8'h00) $display("FAIL reset_outputs cyc%0d: got %h want 00", i, dut_vec());
            else n_pass++;
        end
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(4'b0000);
            n_checks++;
            if (dut_vec() !== {exp_pulse, exp_held}) $display("FAIL reset_idle cyc%0d: got %h want %h", i, dut_vec(), {exp_pulse, exp_held});
            else n_pass++;
        end
    endtask

    task automatic test_clean_press();
        int npulse = 0, pulse_at = -1, drop_at = -1;
        for (int i = 0; i < 45; i++) begin
            tick((i < 30) ? 4'b0001 : 4'b0000);
            n_checks++;
            if (dut_vec() !== {exp_pulse, exp_held}) $display("FAIL clean_model cyc%0d: got %h want %h", i, dut_vec(), {exp_pulse, exp_held});
            else n_pass++;
            if (food_button) begin npulse++; if (pulse_at < 0) pulse_at = i; end
            if (i >= 30 && drop_at < 0 && !btn_held[0]) drop_at = i - 30;
        end
        n_checks++; if (npulse !== 1) $display("FAIL clean_count: got %0d want 1", npulse); else n_pass++;
        n_checks++; if (pulse_at !== 6) $display("FAIL clean_latency: got %0d want 6", pulse_at); else n_pass++;
        n_checks++; if (drop_at !== 6) $display("FAIL clean_release: got %0d want 6", drop_at); else n_pass++;
    endtask

    task automatic test_bounce();
        int npulse = 0, pulse_at = -1;
        logic v;
        for (int i = 0; i < 80; i++) begin
            if (i < 20) v = ((i / 2) % 2) == 0;
            else if (i >= 40 && i < 43) v = 1'b0;
            else if (i >= 60) v = 1'b0;
            else v = 1'b1;
            tick({2'b00, v, 1'b0});
            n_checks++;
            if (dut_vec() !== {exp_pulse, exp_held}) $display("FAIL bounce_model cyc%0d: got %h want %h", i, dut_vec(), {exp_pulse, exp_held});
            else n_pass++;
            if (heal_button) begin npulse++; if (pulse_at < 0) pulse_at = i - 20; end
        end
        n_checks++; if (npulse !== 1) $display("FAIL bounce_count: got %0d want 1", npulse); else n_pass++;
        n_checks++; if (pulse_at !== 6) $display("FAIL bounce_latency: got %0d want 6", pulse_at); else n_pass++;
    endtask

    task automatic test_long_press();
        int npulse = 0, pulse_at = -1, nshort = 0;
        for (int i = 0; i < 55; i++) begin
            tick((i < 40) ? 4'b1000 : 4'b0000);
            n_checks++;
            if (dut_vec() !== {exp_pulse, exp_held}) $display("FAIL long_model cyc%0d: got %h want %h", i, dut_vec(), {exp_pulse, exp_held});
            else n_pass++;
            if (test_signal) begin npulse++; if (pulse_at < 0) pulse_at = i; end
        end
        for (int i = 0; i < 30; i++) begin
            tick((i < 15) ? 4'b1000 : 4'b0000);
            n_checks++;
            if (dut_vec() !== {exp_pulse, exp_held}) $display("FAIL short_model cyc%0d: got %h want %h", i, dut_vec(), {exp_pulse, exp_held});
            else n_pass++;
            if (test_signal) nshort++;
        end
        n_checks++; if (npulse !== 1) $display("FAIL long_count: got %0d want 1", npulse); else n_pass++;
        n_checks++; if (pulse_at !== 6 + LONG) $display("FAIL long_latency: got %0d want %0d", pulse_at, 6 + LONG); else n_pass++;
        n_checks++; if (nshort !== 0) $display("FAIL short_count: got %0d want 0", nshort); else n_pass++;
    endtask

    task automatic test_simultaneous();
        int nf = 0, nh = 0, fat = -1, hat = -1;
        for (int i = 0; i < 32; i++) begin
            tick((i < 20) ? 4'b0011 : 4'b0000);
            n_checks++;
            if (dut_vec() !== {exp_pulse, exp_held}) $display("FAIL simul_model cyc%0d: got %h want %h", i, dut_vec(), {exp_pulse, exp_held});
            else n_pass++;
            if (food_button) begin nf++; fat = i; end
            if (heal_button) begin nh++; hat = i; end
        end
        n_checks++; if (nf !== 1 || nh !== 1) $display("FAIL simul_count: got %0d/%0d want 1/1", nf, nh); else n_pass++;
        n_checks++; if (fat !== 6 || hat !== 6) $display("FAIL simul_cycle: got %0d/%0d want 6/6", fat, hat); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int npulse = 0, pulse_at = -1;
        for (int i = 0; i < 5; i++) tick(4'b0100);
        rst = 1'b0;
        #1;
        n_checks++; if (dut_vec() !== 8'h00) $display("FAIL midrst_async: got %h want 00", dut_vec()); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick(4'b0100);
            n_checks++; if (dut_vec() !== 8'h00) $display("FAIL midrst_hold cyc%0d: got %h want 00", i, dut_vec()); else n_pass++;
        end
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick((i < 15) ? 4'b0100 : 4'b0000);
            n_checks++;
            if (dut_vec() !== {exp_pulse, exp_held}) $display("FAIL midrst_model cyc%0d: got %h want %h", i, dut_vec(), {exp_pulse, exp_held});
            else n_pass++;
            if (state_button) begin npulse++; if (pulse_at < 0) pulse_at = i; end
        end
        n_checks++; if (npulse !== 1) $display("FAIL midrst_count: got %0d want 1", npulse); else n_pass++;
        n_checks++; if (pulse_at !== 6) $display("FAIL midrst_latency: got %0d want 6", pulse_at); else n_pass++;
    endtask

    task automatic test_autorepeat();
        int npulse = 0, nafter = 0;
`ifdef STATE_AUTOREPEAT_EN
        int want = 6;
`else
        int want = 1;
`endif
        for (int i = 0; i < 75; i++) begin
            tick((i < 60) ? 4'b0100 : 4'b0000);
            n_checks++;
            if (dut_vec() !== {exp_pulse, exp_held}) $display("FAIL repeat_model cyc%0d: got %h want %h", i, dut_vec(), {exp_pulse, exp_held});
            else n_pass++;
            if (state_button) npulse++;
            if (state_button && i >= 62) nafter++;
        end
        n_checks++; if (npulse !== want) $display("FAIL repeat_count: got %0d want %0d", npulse, want); else n_pass++;
        n_checks++; if (nafter !== 0) $display("FAIL repeat_after_release: got %0d want 0", nafter); else n_pass++;
    endtask

    task automatic test_random();
        int run [4];
        logic [3:0] cur = 4'b0000;
        for (int b = 0; b < 4; b++) run[b] = 0;
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (run[b] == 0) begin
                    cur[b] = ~cur[b];
                    run[b] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 5) : $urandom_range(6, (b == 3) ? 45 : 35);
                end
                run[b]--;
            end
            if (i == 400 || i == 401) rst = 1'b0;
            else rst = 1'b1;
            tick(cur);
            n_checks++;
            if (dut_vec() !== {exp_pulse, exp_held}) $display("FAIL random_model cyc%0d: got %h want %h", i, dut_vec(), {exp_pulse, exp_held});
            else n_pass++;
        end
        rst = 1'b1;
        for (int i = 0; i < 12; i++) tick(4'b0000);
    endtask

    initial begin
        rst = 1'b0;
        {test_raw, state_raw, heal_raw, food_raw} = 4'b0000;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_simultaneous();
        test_reset_mid();
        test_autorepeat();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
